stream_checker: RTL and testbench

Self-checking sink that sits directly downstream of a generated dataflow graph's `out` operator, in place of the plain consumer. It issues requests on the graph's output handshake, captures each returned token and compares it against an affine expected sequence. It accumulates throughput, gap and error statistics and raises `done` and `pass` flags for the bench top.

---
 rtl/stream_checker.sv | 135 +++++++++++++
 tb/tb_stream_checker.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_checker.sv
// Self-checking sink for a dataflow graph output: requests tokens, compares them against an
// affine expected sequence and keeps throughput, gap and error statistics.
module stream_checker #(
    parameter int unsigned data_width      = 32,
    parameter int unsigned max_data_size   = 5000,
    parameter int unsigned init_value      = 0,
    parameter int unsigned exp_mul         = 3,
    parameter int unsigned exp_add         = 2,
    parameter int unsigned stall_threshold = 0,
    parameter logic [15:0] lfsr_seed       = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  req,
    input  logic                  ack,
    input  logic [data_width-1:0] din,
    output logic [31:0]           count,
    output logic [31:0]           mismatches,
    output logic [31:0]           first_err_idx,
    output logic [data_width-1:0] first_err_data,
    output logic [31:0]           cycles,
    output logic [15:0]           max_gap,
    output logic                  done,
    output logic                  pass
);

    localparam logic [data_width-1:0] exp_init = data_width'(exp_mul * init_value + exp_add);
    localparam logic [data_width-1:0] exp_step = data_width'(exp_mul);

    logic [15:0]           lfsr_q, lfsr_d;
    logic                  ack_q, ack_d;
    logic [15:0]           gap_q, gap_d;
    logic                  err_seen_q, err_seen_d;
    logic [data_width-1:0] exp_q, exp_d;
    logic                  req_q, req_d;
    logic [31:0]           count_q, count_d;
    logic [31:0]           mism_q, mism_d;
    logic [31:0]           fidx_q, fidx_d;
    logic [data_width-1:0] fdata_q, fdata_d;
    logic [31:0]           cycles_q, cycles_d;
    logic [15:0]           max_gap_q, max_gap_d;
    logic                  done_q, done_d;

    logic        acc;
    logic        stall;
    logic [15:0] gap_inc;

    always_comb begin
        lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        ack_d      = ack;
        gap_d      = gap_q;
        err_seen_d = err_seen_q;
        exp_d      = exp_q;
        count_d    = count_q;
        mism_d     = mism_q;
        fidx_d     = fidx_q;
        fdata_d    = fdata_q;
        cycles_d   = cycles_q;
        max_gap_d  = max_gap_q;

        // Rising edge of ack is the accept event, so a held ack counts once.
        acc     = ack && !ack_q && !done_q;
        gap_inc = (gap_q == 16'hFFFF) ? gap_q : gap_q + 16'd1;
        stall   = {24'd0, lfsr_q[7:0]} < stall_threshold;

        if (acc) begin
            count_d = count_q + 32'd1;
            exp_d   = exp_q + exp_step;
            if (din != exp_q) begin
                mism_d = mism_q + 32'd1;
                if (!err_seen_q) begin
                    fidx_d     = count_q;
                    fdata_d    = din;
                    err_seen_d = 1'b1;
                end
            end
            if (gap_inc > max_gap_q) begin
                max_gap_d = gap_inc;
            end
            gap_d = 16'd0;
        end else if (!done_q) begin
            gap_d = gap_inc;
        end

        if (!done_q) begin
            cycles_d = cycles_q + 32'd1;
        end

        done_d = done_q || (count_d >= max_data_size);
        req_d  = !done_d && !stall;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q     <= lfsr_seed;
            ack_q      <= 1'b0;
            gap_q      <= 16'd0;
            err_seen_q <= 1'b0;
            exp_q      <= exp_init;
            req_q      <= 1'b0;
            count_q    <= 32'd0;
            mism_q     <= 32'd0;
            fidx_q     <= 32'd0;
            fdata_q    <= '0;
            cycles_q   <= 32'd0;
            max_gap_q  <= 16'd0;
            done_q     <= 1'b0;
        end else begin
            lfsr_q     <= lfsr_d;
            ack_q      <= ack_d;
            gap_q      <= gap_d;
            err_seen_q <= err_seen_d;
            exp_q      <= exp_d;
            req_q      <= req_d;
            count_q    <= count_d;
            mism_q     <= mism_d;
            fidx_q     <= fidx_d;
            fdata_q    <= fdata_d;
            cycles_q   <= cycles_d;
            max_gap_q  <= max_gap_d;
            done_q     <= done_d;
        end
    end

    assign req            = req_q;
    assign count          = count_q;
    assign mismatches     = mism_q;
    assign first_err_idx  = fidx_q;
    assign first_err_data = fdata_q;
    assign cycles         = cycles_q;
    assign max_gap        = max_gap_q;
    assign done           = done_q;
    assign pass           = done_q && (mism_q == 32'd0);

endmodule

// File: tb/tb_stream_checker.sv
// Directed + randomized bench for stream_checker; four parameterizations share clock and reset,
// and a behavioural model tracks the selected instance.
module tb_stream_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [3:0]       ack_v;
    logic [31:0]      din;
    logic [3:0]       o_req, o_done, o_pass;
    logic [3:0][31:0] o_count, o_mism, o_fidx, o_fdata, o_cycles;
    logic [3:0][15:0] o_maxgap;
    logic [7:0]       w_fdata;

    int unsigned checks = 0;
    int unsigned errors = 0;

    stream_checker #(.max_data_size(8)) u_a (
        .clk(clk), .rst(rst), .req(o_req[0]), .ack(ack_v[0]), .din(din),
        .count(o_count[0]), .mismatches(o_mism[0]), .first_err_idx(o_fidx[0]),
        .first_err_data(o_fdata[0]), .cycles(o_cycles[0]), .max_gap(o_maxgap[0]),
        .done(o_done[0]), .pass(o_pass[0])
    );

    stream_checker #(.stall_threshold(128)) u_s (
        .clk(clk), .rst(rst), .req(o_req[1]), .ack(ack_v[1]), .din(din),
        .count(o_count[1]), .mismatches(o_mism[1]), .first_err_idx(o_fidx[1]),
        .first_err_data(o_fdata[1]), .cycles(o_cycles[1]), .max_gap(o_maxgap[1]),
        .done(o_done[1]), .pass(o_pass[1])
    );

    stream_checker #(.data_width(8), .init_value(84), .max_data_size(4)) u_w (
        .clk(clk), .rst(rst), .req(o_req[2]), .ack(ack_v[2]), .din(din[7:0]),
        .count(o_count[2]), .mismatches(o_mism[2]), .first_err_idx(o_fidx[2]),
        .first_err_data(w_fdata), .cycles(o_cycles[2]), .max_gap(o_maxgap[2]),
        .done(o_done[2]), .pass(o_pass[2])
    );
    assign o_fdata[2] = {24'd0, w_fdata};

    stream_checker #(.max_data_size(0)) u_z (
        .clk(clk), .rst(rst), .req(o_req[3]), .ack(ack_v[3]), .din(din),
        .count(o_count[3]), .mismatches(o_mism[3]), .first_err_idx(o_fidx[3]),
        .first_err_data(o_fdata[3]), .cycles(o_cycles[3]), .max_gap(o_maxgap[3]),
        .done(o_done[3]), .pass(o_pass[3])
    );

    // Reference model state for the selected instance.
    logic [1:0]  m_sel;
    logic [31:0] m_init, m_mul, m_add, m_max, m_mask;
    logic [31:0] m_count, m_mism, m_fidx, m_fdata, m_cycles;
    logic [15:0] m_maxgap;
    bit          m_done, m_err, m_prev, m_chk_req, m_quiet;
    longint      m_edge, m_last;

    function automatic logic [31:0] exp_tok(logic [31:0] idx);
        return (m_mul * (m_init + idx) + m_add) & m_mask;
    endfunction

    task automatic select(logic [1:0] s);
        m_sel = s;
        m_mul = 32'd3;
        m_add = 32'd2;
        m_init = 32'd0;
        m_mask = 32'hFFFF_FFFF;
        m_chk_req = (s != 2'd1);
        case (s)
            2'd0: m_max = 32'd8;
            2'd1: m_max = 32'd5000;
            2'd2: begin
                m_max  = 32'd4;
                m_init = 32'd84;
                m_mask = 32'h0000_00FF;
            end
            default: m_max = 32'd0;
        endcase
    endtask

    task automatic model_edge(bit r, bit a, logic [31:0] d);
        longint g;
        if (r) begin
            m_count = 0; m_mism = 0; m_fidx = 0; m_fdata = 0; m_cycles = 0; m_maxgap = 0;
            m_done = 0; m_err = 0; m_prev = 0; m_edge = 0; m_last = 0;
        end else begin
            m_edge++;
            if (!m_done) m_cycles++;
            if (a && !m_prev && !m_done) begin
                // Gap is the edge distance since the previous accept (or reset), saturating.
                g = m_edge - m_last;
                if (g > 65535) g = 65535;
                if ((d & m_mask) != exp_tok(m_count)) begin
                    m_mism++;
                    if (!m_err) begin
                        m_err   = 1;
                        m_fidx  = m_count;
                        m_fdata = d & m_mask;
                    end
                end
                if (g > longint'(m_maxgap)) m_maxgap = 16'(g);
                m_last = m_edge;
                m_count++;
            end
            m_prev = a;
            if (m_count >= m_max) m_done = 1;
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("count", o_count[m_sel], m_count);
        check("mismatches", o_mism[m_sel], m_mism);
        check("first_err_idx", o_fidx[m_sel], m_fidx);
        check("first_err_data", o_fdata[m_sel], m_fdata);
        check("cycles", o_cycles[m_sel], m_cycles);
        check("max_gap", {16'd0, o_maxgap[m_sel]}, {16'd0, m_maxgap});
        check("done", {31'd0, o_done[m_sel]}, {31'd0, m_done});
        check("pass", {31'd0, o_pass[m_sel]}, {31'd0, m_done && (m_mism == 0)});
        if (m_chk_req)
            check("req", {31'd0, o_req[m_sel]}, {31'd0, (m_edge > 0) && !m_done});
    endtask

    task automatic tick(bit a, logic [31:0] d);
        ack_v = 4'd0;
        ack_v[m_sel] = a;
        din = d;
        @(posedge clk);
        model_edge(rst, a, d);
        #1;
        if (!m_quiet) check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, 32'd0);
        rst = 1'b0;
    endtask

    task automatic pulse(logic [31:0] d, int low);
        tick(1'b1, d);
        repeat (low) tick(1'b0, 32'd0);
    endtask

    int          hold, hi;
    logic [31:0] dd;
    int          spacing [3] = '{2, 7, 3};
    logic [31:0] wrap_tok [4] = '{32'd254, 32'd1, 32'd4, 32'd7};

    initial begin
        rst = 1'b0; ack_v = 4'd0; din = 32'd0; m_quiet = 0;

        // Correct stream 2, 5, ..., 23, then acks after done are ignored.
        select(2'd0);
        do_reset();
        for (int i = 0; i < 8; i++) pulse(exp_tok(32'(i)), $urandom_range(1, 3));
        check("stream_count", o_count[0], 32'd8);
        check("stream_pass", {31'd0, o_pass[0]}, 32'd1);
        repeat (3) pulse(32'd26, 1);
        check("stream_frozen", o_count[0], 32'd8);
        check("stream_req_off", {31'd0, o_req[0]}, 32'd0);

        // Single corruption at token 3.
        do_reset();
        for (int i = 0; i < 8; i++) pulse((i == 3) ? 32'd99 : exp_tok(32'(i)), 1);
        check("corr_mism", o_mism[0], 32'd1);
        check("corr_idx", o_fidx[0], 32'd3);
        check("corr_data", o_fdata[0], 32'd99);
        check("corr_pass", {31'd0, o_pass[0]}, 32'd0);

        // Held ack counts once.
        do_reset();
        repeat (4) tick(1'b1, 32'd2);
        tick(1'b0, 32'd0);
        check("held_count", o_count[0], 32'd1);
        check("held_mism", o_mism[0], 32'd0);

        // Accepts spaced 2, 7, 3 apart.
        do_reset();
        tick(1'b0, 32'd0);
        tick(1'b1, exp_tok(32'd0));
        for (int k = 0; k < 3; k++) begin
            repeat (spacing[k] - 1) tick(1'b0, 32'd0);
            tick(1'b1, exp_tok(m_count));
        end
        tick(1'b0, 32'd0);
        check("gap_max", {16'd0, o_maxgap[0]}, 32'd7);

        // Randomized streams with random hold lengths, gaps and corruptions.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int p = 0; p < 12; p++) begin
                hold = $urandom_range(1, 3);
                dd = exp_tok(m_count);
                if ($urandom_range(0, 3) == 0) dd = $urandom;
                repeat (hold) tick(1'b1, dd);
                repeat ($urandom_range(1, 4)) tick(1'b0, 32'd0);
            end
        end

        // No acks for a long time: gap saturates, max_gap stays 0 until the next accept.
        do_reset();
        m_quiet = 1;
        repeat (66000) tick(1'b0, 32'd0);
        m_quiet = 0;
        check_all();
        check("idle_gap_sat", {16'd0, u_a.gap_q}, 32'h0000_FFFF);
        tick(1'b1, exp_tok(32'd0));
        tick(1'b0, 32'd0);
        check("sat_max_gap", {16'd0, o_maxgap[0]}, 32'h0000_FFFF);

        // Stalling: req duty near half, stalled-cycle ack still accepted.
        select(2'd1);
        do_reset();
        hi = 0;
        repeat (1000) begin
            tick(1'b0, 32'd0);
            hi += int'(o_req[1]);
        end
        check("req_duty", {31'd0, (hi >= 400) && (hi <= 600)}, 32'd1);
        for (int k = 0; k < 64 && o_req[1]; k++) tick(1'b0, 32'd0);
        check("stall_seen", {31'd0, o_req[1]}, 32'd0);
        pulse(exp_tok(m_count), 1);
        check("stall_acc", o_count[1], 32'd1);
        pulse(exp_tok(m_count), 2);
        pulse(exp_tok(m_count), 2);
        check("pre_rst_count", o_count[1], 32'd3);
        // Reset with a token in flight: dropped, everything back to zero.
        rst = 1'b1;
        tick(1'b1, exp_tok(m_count));
        rst = 1'b0;
        check("rst_count", o_count[1], 32'd0);
        check("rst_cycles", o_cycles[1], 32'd0);
        tick(1'b0, 32'd0);
        pulse(32'd2, 1);
        check("post_rst_count", o_count[1], 32'd1);
        check("post_rst_mism", o_mism[1], 32'd0);

        // 8-bit wrap-around: 254, 1, 4, 7.
        select(2'd2);
        do_reset();
        for (int i = 0; i < 4; i++) pulse(wrap_tok[i], 1);
        check("wrap_pass", {31'd0, o_pass[2]}, 32'd1);
        check("wrap_mism", o_mism[2], 32'd0);

        // Zero-size run: done immediately, req never asserts.
        select(2'd3);
        do_reset();
        tick(1'b0, 32'd0);
        check("zero_done", {31'd0, o_done[3]}, 32'd1);
        repeat (3) pulse(32'd2, 1);
        check("zero_req", {31'd0, o_req[3]}, 32'd0);
        check("zero_count", o_count[3], 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
